// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: forwarding selects, stall/flush generation and a
// scoreboard for out-of-band multi-cycle results. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_unit #(
   parameter int MC_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_d,
   input  logic [4:0]  rs2_d,
   input  logic [4:0]  rd_d,
   input  logic        reg_write_d,
   input  logic        mc_d,
   input  logic [4:0]  rs1_e,
   input  logic [4:0]  rs2_e,
   input  logic [4:0]  rd_e,
   input  logic        load_e,
   input  logic        mc_issue_e,
   input  logic        pc_src_e,
   input  logic [4:0]  rd_m,
   input  logic        reg_write_m,
   input  logic [4:0]  rd_w,
   input  logic        reg_write_w,
   input  logic        mc_done,
   input  logic [4:0]  mc_done_rd,
   output logic [1:0]  forward_a_e,
   output logic [1:0]  forward_b_e,
   output logic        stall_f,
   output logic        stall_d,
   output logic        flush_d,
   output logic        flush_e,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);
   localparam int NUM_SRC = 2;
   localparam int OC_W    = $clog2(MC_DEPTH + 1);
   localparam logic [OC_W-1:0] OC_MAX = OC_W'(MC_DEPTH);

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic flush_d;
      logic flush_e;
   } ctrl_t;

   logic [31:1]                 pend_q;
   logic [31:1]                 pend_nxt;
   logic [31:0]                 pend_eff;
   logic [OC_W-1:0]             oc;
   logic [OC_W-1:0]             oc_nxt;
   logic [OC_W-1:0]             oc_eff;
   logic [NUM_SRC-1:0][4:0]     rs_e_v;
   logic [NUM_SRC-1:0][4:0]     rs_d_v;
   logic [NUM_SRC-1:0][1:0]     fwd_v;
   logic [NUM_SRC-1:0]          src_hz;
   logic                        e_rd_nz;
   logic                        waw_hz;
   logic                        struct_hz;
   logic                        stall_hz;
   ctrl_t                       ctrl;

   assign rs_e_v  = {rs2_e, rs1_e};
   assign rs_d_v  = {rs2_d, rs1_d};
   assign e_rd_nz = (rd_e != 5'd0);

   // A completing result is visible through the write-through register file this cycle.
   always_comb begin
      pend_eff    = '0;
      pend_nxt    = '0;
      for (int r = 1; r < 32; r++) begin
         pend_eff[r] = pend_q[r] && !(mc_done && mc_done_rd == 5'(r));
         pend_nxt[r] = pend_eff[r] || (mc_issue_e && rd_e == 5'(r));
      end
   end

   assign oc_eff = (mc_done && oc != '0) ? oc - OC_W'(1) : oc;

   // Per-source forwarding and decode-side source hazards.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic hit_m, hit_w, hit_e;
      assign hit_m     = reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e_v[i]);
      assign hit_w     = reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e_v[i]);
      assign fwd_v[i]  = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
      assign hit_e     = e_rd_nz && (rd_e == rs_d_v[i]) && (load_e || mc_issue_e);
      assign src_hz[i] = hit_e || pend_eff[rs_d_v[i]];
   end

   assign waw_hz    = reg_write_d && pend_eff[rd_d];
   assign struct_hz = mc_d && (oc_eff == OC_MAX);
   assign stall_hz  = (|src_hz) || waw_hz || struct_hz;

   // A taken branch wins over a stall: D holds a wrong-path instruction anyway.
   always_comb begin
      ctrl = '{stall_f: 1'b0, stall_d: 1'b0, flush_d: 1'b1, flush_e: 1'b1};
      if (!rst) begin
         ctrl.stall_f = stall_hz && !pc_src_e;
         ctrl.stall_d = stall_hz && !pc_src_e;
         ctrl.flush_d = pc_src_e;
         ctrl.flush_e = stall_hz || pc_src_e;
      end
   end

   assign forward_a_e = rst ? 2'b00 : fwd_v[0];
   assign forward_b_e = rst ? 2'b00 : fwd_v[1];
   assign stall_f     = ctrl.stall_f;
   assign stall_d     = ctrl.stall_d;
   assign flush_d     = ctrl.flush_d;
   assign flush_e     = ctrl.flush_e;

   always_comb begin
      case ({mc_issue_e, mc_done})
         2'b10:   oc_nxt = (oc == OC_MAX) ? oc : oc + OC_W'(1);
         2'b01:   oc_nxt = (oc == '0) ? oc : oc - OC_W'(1);
         default: oc_nxt = oc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         oc     <= '0;
      end else begin
         pend_q <= pend_nxt;
         oc     <= oc_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ctrl.stall_d) stall_cnt <= stall_cnt + 32'd1;
         if (pc_src_e)     flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt;
   assign perf_flush_cnt = flush_cnt;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

`ifndef SYNTHESIS
   a_done_empty: assert property (@(posedge clk) disable iff (rst) !(mc_done && oc == '0));
   a_issue_full: assert property (@(posedge clk) disable iff (rst) !(mc_issue_e && oc == OC_MAX));
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed cases with literal expectations plus randomized traffic,
// all compared every cycle against a behavioural scoreboard model.
module tb_hazard_unit;
   localparam int MC_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mc_done_rd;
   logic        reg_write_d, mc_d, load_e, mc_issue_e, pc_src_e;
   logic        reg_write_m, reg_write_w, mc_done;
   logic [1:0]  forward_a_e, forward_b_e;
   logic        stall_f, stall_d, flush_d, flush_e;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;

   always #5 clk = ~clk;

   hazard_unit #(.MC_DEPTH(MC_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .reg_write_d(reg_write_d), .mc_d(mc_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .load_e(load_e), .mc_issue_e(mc_issue_e), .pc_src_e(pc_src_e),
      .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w),
      .mc_done(mc_done), .mc_done_rd(mc_done_rd),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: set of registers awaiting a multi-cycle result, and the list of
   // outstanding multi-cycle ops (its length is the outstanding count).
   bit          pend_m[32];
   int          mcq[$];
   logic [31:0] stall_m, flush_m;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_exp(logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit busy(logic [4:0] r);
      return (r != 0) && pend_m[r] && !(mc_done && mc_done_rd == r);
   endfunction

   function automatic bit hz_exp();
      bit use_e;
      use_e = (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
      return (load_e && use_e) || (mc_issue_e && use_e) ||
             busy(rs1_d) || busy(rs2_d) || (reg_write_d && busy(rd_d)) ||
             (mc_d && (mcq.size() - (mc_done ? 1 : 0)) == MC_DEPTH);
   endfunction

   // Reference model state advance.
   always @(posedge clk) begin
      if (rst) begin
         foreach (pend_m[r]) pend_m[r] = 1'b0;
         mcq.delete();
         stall_m = 0;
         flush_m = 0;
      end else begin
         if (hz_exp() && !pc_src_e) stall_m = stall_m + 1;
         if (pc_src_e) flush_m = flush_m + 1;
         if (mc_done) begin
            pend_m[mc_done_rd] = 1'b0;
            for (int i = 0; i < mcq.size(); i++)
               if (mcq[i] == int'(mc_done_rd)) begin
                  mcq.delete(i);
                  break;
               end
         end
         if (mc_issue_e) begin
            if (rd_e != 0) pend_m[rd_e] = 1'b1;
            mcq.push_back(int'(rd_e));
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      bit hz;
      hz = hz_exp();
      if (rst) begin
         check("m_fwd_a", forward_a_e, 0);
         check("m_fwd_b", forward_b_e, 0);
         check("m_stall_f", stall_f, 0);
         check("m_stall_d", stall_d, 0);
         check("m_flush_d", flush_d, 1);
         check("m_flush_e", flush_e, 1);
      end else begin
         check("m_fwd_a", forward_a_e, fwd_exp(rs1_e));
         check("m_fwd_b", forward_b_e, fwd_exp(rs2_e));
         check("m_stall_f", stall_f, hz && !pc_src_e);
         check("m_stall_d", stall_d, hz && !pc_src_e);
         check("m_flush_d", flush_d, pc_src_e);
         check("m_flush_e", flush_e, hz || pc_src_e);
      end
`ifdef HAZARD_PERF_CNT_EN
      check("m_perf_stall", perf_stall_cnt, stall_m);
      check("m_perf_flush", perf_flush_cnt, flush_m);
`else
      check("m_perf_stall", perf_stall_cnt, 0);
      check("m_perf_flush", perf_flush_cnt, 0);
`endif
   end

   task automatic idle();
      rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0; mc_d = 0;
      rs1_e = 0; rs2_e = 0; rd_e = 0; load_e = 0; mc_issue_e = 0; pc_src_e = 0;
      rd_m = 0; reg_write_m = 0; rd_w = 0; reg_write_w = 0;
      mc_done = 0; mc_done_rd = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      int pick;
      idle();
      rst = 1;
      reg_write_m = 1; rd_m = 5; rs1_e = 5; load_e = 1; rd_e = 7; rs1_d = 7;
      smp();
      check("rst_fwd_a", forward_a_e, 0);
      check("rst_stall_d", stall_d, 0);
      check("rst_flush_d", flush_d, 1);
      check("rst_flush_e", flush_e, 1);
      nxt();
      rst = 0; idle();

      // forwarding priority
      reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 5;
      smp(); check("fwd_m_prio", forward_a_e, 2'b10); check("fwd_b_m", forward_b_e, 2'b10);
      nxt(); rd_m = 0;
      smp(); check("fwd_w", forward_a_e, 2'b01);
      nxt(); rd_m = 5; rs1_e = 0;
      smp(); check("fwd_x0", forward_a_e, 2'b00);
      nxt(); idle();

      // load-use: one bubble
      load_e = 1; rd_e = 7; rs2_d = 7;
      smp();
      check("lu_stall_f", stall_f, 1); check("lu_stall_d", stall_d, 1);
      check("lu_flush_e", flush_e, 1); check("lu_flush_d", flush_d, 0);
      nxt(); load_e = 0;
      smp(); check("lu_after_stall", stall_d, 0); check("lu_after_flush_e", flush_e, 0);
      nxt(); idle();

      // taken branch overrides stall
      load_e = 1; rd_e = 7; rs2_d = 7; pc_src_e = 1;
      smp();
      check("br_stall_f", stall_f, 0); check("br_stall_d", stall_d, 0);
      check("br_flush_d", flush_d, 1); check("br_flush_e", flush_e, 1);
      nxt(); idle();

      // multi-cycle RAW on x9
      mc_issue_e = 1; rd_e = 9; rs1_d = 9;
      smp(); check("mc_use_e", stall_d, 1);
      nxt(); mc_issue_e = 0; rd_e = 0;
      for (int i = 0; i < 3; i++) begin
         smp(); check("mc_raw_wait", stall_d, 1);
         nxt();
      end
      mc_done = 1; mc_done_rd = 9; reg_write_w = 1; rd_w = 9;
      smp(); check("mc_raw_done", stall_d, 0);
      nxt(); mc_done = 0; reg_write_w = 0; rd_w = 0;
      smp(); check("mc_raw_cleared", stall_d, 0);
      nxt(); idle();

      // structural limit and done/issue collision
      mc_issue_e = 1; rd_e = 3; nxt();
      rd_e = 4; nxt();
      mc_issue_e = 0; rd_e = 0; mc_d = 1;
      smp(); check("struct_full", stall_d, 1);
      nxt(); mc_done = 1; mc_done_rd = 3;
      smp(); check("struct_done_bypass", stall_d, 0);
      nxt(); mc_d = 0; mc_done = 1; mc_done_rd = 4; mc_issue_e = 1; rd_e = 4;
      nxt(); mc_done = 0; mc_issue_e = 0; rd_e = 0; rs1_d = 4;
      smp(); check("collide_set_wins", stall_d, 1);
      nxt(); rs1_d = 0; mc_issue_e = 1; rd_e = 5;
      nxt(); mc_issue_e = 0; rd_e = 0; mc_d = 1;
      smp(); check("collide_oc_kept", stall_d, 1);

      // reset mid-flight discards tracking
      nxt(); mc_d = 0; rst = 1;
      nxt(); rst = 0; rs1_d = 4; rs2_d = 5; mc_d = 1;
      smp(); check("rst_mid_clear", stall_d, 0);
      nxt(); idle();

      // perf counters: 3 stall cycles, 2 branches
      rst = 1; nxt(); rst = 0;
      load_e = 1; rd_e = 7; rs1_d = 7;
      repeat (3) nxt();
      idle(); pc_src_e = 1;
      repeat (2) nxt();
      idle();
      smp();
`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall_3", perf_stall_cnt, 3);
      check("perf_flush_2", perf_flush_cnt, 2);
`else
      check("perf_stall_off", perf_stall_cnt, 0);
      check("perf_flush_off", perf_flush_cnt, 0);
`endif
      nxt();

      // randomized traffic, legal multi-cycle protocol
      repeat (3000) begin
         idle();
         rst         = ($urandom_range(0, 99) == 0);
         rs1_d       = 5'($urandom_range(0, 7));
         rs2_d       = 5'($urandom_range(0, 7));
         rd_d        = 5'($urandom_range(0, 7));
         reg_write_d = 1'($urandom_range(0, 1));
         mc_d        = ($urandom_range(0, 2) == 0);
         rs1_e       = 5'($urandom_range(0, 7));
         rs2_e       = 5'($urandom_range(0, 7));
         rd_e        = 5'($urandom_range(0, 7));
         rd_m        = 5'($urandom_range(0, 7));
         reg_write_m = 1'($urandom_range(0, 1));
         rd_w        = 5'($urandom_range(0, 7));
         reg_write_w = 1'($urandom_range(0, 1));
         pc_src_e    = ($urandom_range(0, 7) == 0);
         mc_issue_e  = !rst && mcq.size() < MC_DEPTH && ($urandom_range(0, 2) == 0);
         load_e      = !mc_issue_e && ($urandom_range(0, 3) == 0);
         if (!rst && mcq.size() > 0 && $urandom_range(0, 2) == 0) begin
            pick        = $urandom_range(0, mcq.size() - 1);
            mc_done     = 1;
            mc_done_rd  = 5'(mcq[pick]);
            reg_write_w = 1;
            rd_w        = mc_done_rd;
         end
         nxt();
      end
      idle();
      rst = 0;
      smp();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core: the producer of the forwarding selects consumed by the execute stage and the consumer of its `rs1_e`/`rs2_e`/`pc_src_e` outputs. Combinationally generates forwarding, stall and flush controls. Holds a register scoreboard for multi-cycle (FPU/divider) results that retire out of band through write-back. Optional performance counters.

## Interface
- `MC_DEPTH`, 4: max outstanding multi-cycle ops (≥1).
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `rs1_d`, `rs2_d`, `rd_d  in  5`: decode-stage source and destination registers.
- `reg_write_d`, `mc_d  in  1`: decode instruction writes a register / is a multi-cycle op.
- `rs1_e`, `rs2_e`, `rd_e  in  5`: execute-stage registers.
- `load_e`, `mc_issue_e  in  1`: E holds a load / a multi-cycle op issuing this cycle.
- `pc_src_e  in  1`: taken branch or jump in E.
- `rd_m  in  5`, `reg_write_m  in  1`: M-stage destination and write enable.
- `rd_w  in  5`, `reg_write_w  in  1`: W-stage destination and write enable.
- `mc_done  in  1`, `mc_done_rd  in  5`: a multi-cycle op completes; it writes back this cycle via W.
- `forward_a_e`, `forward_b_e  out  2`: `00` = register file, `01` = `result_w`, `10` = `alu_result_m`.
- `stall_f`, `stall_d`, `flush_d`, `flush_e  out  1`: pipeline controls.
- `perf_stall_cnt`, `perf_flush_cnt  out  32`: performance counters.

## Operation
- **Forwarding** (per source, shown for A):
  - `10` if `reg_write_m && rd_m!=0 && rd_m==rs1_e`.
  - Else `01` if `reg_write_w && rd_w!=0 && rd_w==rs1_e`.
  - Else `00`.
  - M has priority over W. x0 is never forwarded.
- **M-stage write enable:** multi-cycle ops travel through M with `reg_write_m=0`. Their result appears only at completion, with `reg_write_w=1` and `rd_w=mc_done_rd`.
- **Scoreboard state:**
  - `pending[31:1]` bits, `pending[0]` hard 0.
  - Outstanding counter `oc`, 0..`MC_DEPTH`.
  - Effective view: `pend_eff = pending & ~(mc_done ? onehot(mc_done_rd) : 0)`. The register file is write-through, so a completing result is readable in D the same cycle.
- **Stall conditions (any → `stall_hz`):**
  - Load-use: `load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d)`.
  - MC-use in E: `mc_issue_e && rd_e!=0 && rd_e matches rs1_d/rs2_d`.
  - RAW: `pend_eff[rs1_d] || pend_eff[rs2_d]`.
  - WAW: `reg_write_d && pend_eff[rd_d]`.
  - Structural: `mc_d && oc_eff==MC_DEPTH`, where `oc_eff = oc - mc_done`.
- **Control outputs:**
  - `stall_f = stall_d = stall_hz && !pc_src_e`.
  - `flush_e = stall_hz || pc_src_e`.
  - `flush_d = pc_src_e`.
  - A taken branch overrides a stall: the D instruction is wrong-path, so the pipeline must advance to the target.
- **Scoreboard update** (clock edge, when not in reset):
  - Clear `pending[mc_done_rd]` if `mc_done`.
  - Then set `pending[rd_e]` if `mc_issue_e && rd_e!=0`. Set wins on the same register.
  - `oc <= oc + mc_issue_e - mc_done`.
- **Illegal:** `mc_done` with `oc==0`, or issue with `oc==MC_DEPTH`. Under simulation an assertion fires; `oc` saturates at 0/`MC_DEPTH`.

## Timing
- All outputs are combinational from inputs and current state: zero-cycle latency.
- Scoreboard and counters update on rising `clk`.
- Reset (synchronous, `rst` high at edge): `pending=0`, `oc=0`, perf counters 0.
- While `rst` is high the outputs are forced: `forward_*=00`, `stall_f=stall_d=0`, `flush_d=flush_e=1`.
- Reset asserted mid-operation discards all outstanding multi-cycle tracking. The multi-cycle unit is reset by the same `rst`.
- Load-use costs exactly 1 bubble. A RAW on a multi-cycle result stalls until the cycle `mc_done` for that register is high; D proceeds in that same cycle.
- Same-cycle `mc_done` and `mc_issue_e`: `oc` unchanged; pending follows set-wins.

## Configuration
- `HAZARD_PERF_CNT_EN`: when defined, two 32-bit wrap-around counters, cleared on reset:
  - `perf_stall_cnt` increments each cycle `stall_d=1`.
  - `perf_flush_cnt` increments each cycle `pc_src_e=1`.
- When undefined, the ports remain and are driven constant 0; no counter flops are built.

## Test plan
- **Forwarding priority:** `reg_write_m=1, rd_m=5`, `reg_write_w=1, rd_w=5`, `rs1_e=5` -> `forward_a_e=10`. Same with `rd_m=0` -> `01`. Same with `rs1_e=0` -> `00`.
- **Load-use:** `load_e=1, rd_e=7, rs2_d=7` -> `stall_f=stall_d=flush_e=1`, `flush_d=0` for 1 cycle. Next cycle with `load_e=0` -> all 0.
- **Branch over stall:** load-use condition plus `pc_src_e=1` -> `stall_f=stall_d=0`, `flush_d=flush_e=1`.
- **Multi-cycle RAW:**
  - Issue with `rd_e=9`; decode `rs1_d=9` held.
  - Expect `stall_d=1` every cycle until the `mc_done=1, mc_done_rd=9` cycle, where `stall_d=0`.
  - `pending[9]=0` afterwards.
- **Structural and collision:**
  - `MC_DEPTH=2`: issue `rd=3` and `rd=4`; then `mc_d=1` -> stall.
  - `mc_done` for 3 -> stall drops the same cycle.
  - Simultaneous `mc_done` for 4 with a new issue to 4 -> `pending[4]` remains 1, `oc` unchanged.
- **Reset mid-flight / perf counters:**
  - `rst` with 2 ops pending -> next cycle `pending=0`, `oc=0`, no stalls.
  - With `HAZARD_PERF_CNT_EN`: 3 stall cycles plus 2 branches -> counters read 3 and 2.
